// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed little-endian program image over a byte stream,
// writes it into instruction memory, and releases the core from reset after a good checksum.
module program_loader #(
    parameter int ADDR_WIDTH  = 10,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [32:0]   CAPACITY  = 33'(1) << ADDR_WIDTH;
    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t                state_q, state_d;
    logic [1:0]            byte_q, byte_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            sum_q, sum_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  corerst_q, corerst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic        accept;
    logic [31:0] len_next;
    logic [31:0] word_next;

    assign accept    = rx_valid && ready_q;
    // Bytes enter at the top and shift down, so the first byte ends up in bits 7:0.
    assign len_next  = {rx_data, len_q[31:8]};
    assign word_next = {rx_data, word_q[31:8]};

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        len_d   = len_q;
        word_d  = word_q;
        sum_d   = sum_q;
        widx_d  = widx_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_LEN: begin
                if (accept) begin
                    len_d  = len_next;
                    sum_d  = sum_q + rx_data;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if ({1'b0, len_next} > CAPACITY) state_d = S_ERROR;
                        else if (len_next == 32'd0)      state_d = S_CSUM;
                        else                             state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d = word_next;
                    sum_d  = sum_q + rx_data;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = word_next;
                        addr_d  = widx_q[ADDR_WIDTH-1:0];
                        widx_d  = widx_q + 1'b1;
                        if (32'(widx_q) == len_q - 32'd1) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    hold_d  = '0;
                    state_d = (rx_data == sum_q) ? S_HOLD : S_ERROR;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) state_d = S_RUN;
                else                     hold_d  = hold_q + 1'b1;
            end
            default: ;
        endcase

        // Status outputs are registered from the next state so they change only on an edge.
        ready_d   = state_d inside {S_LEN, S_DATA, S_CSUM};
        corerst_d = (state_d != S_RUN);
        done_d    = (state_d == S_RUN);
        err_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_LEN;
            byte_q    <= '0;
            len_q     <= '0;
            word_q    <= '0;
            sum_q     <= '0;
            widx_q    <= '0;
            hold_q    <= '0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            corerst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            len_q     <= len_d;
            word_q    <= word_d;
            sum_q     <= sum_d;
            widx_q    <= widx_d;
            hold_q    <= hold_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            corerst_q <= corerst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rx_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = corerst_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, stalled, bad checksum, oversize, empty and async reset.
module tb_program_loader;

    logic        clock;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    logic        s_rx_valid;
    logic [7:0]  s_rx_data;
    logic        s_rx_ready;
    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic        s_core_reset;
    logic        s_done;
    logic        s_error;

    int checks;
    int failures;

    program_loader #(.ADDR_WIDTH(10), .HOLD_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done), .error(error)
    );

    program_loader #(.ADDR_WIDTH(2), .HOLD_CYCLES(4)) dut_s (
        .clock(clock), .reset(reset), .rx_valid(s_rx_valid), .rx_data(s_rx_data),
        .rx_ready(s_rx_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .core_reset(s_core_reset), .done(s_done), .error(s_error)
    );

    localparam logic [7:0] NOM [13] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                        8'h93, 8'h00, 8'h00, 8'h00,
                                        8'h13, 8'h01, 8'h10, 8'h00, 8'hB9};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          wr_total;
    logic [9:0]  wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    int          s_wr_total;
    logic [1:0]  s_last_addr;
    logic [31:0] s_last_data;

    initial begin
        wr_total   = 0;
        s_wr_total = 0;
    end

    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            wr_addr_log[wr_total % 64] <= imem_addr;
            wr_data_log[wr_total % 64] <= imem_wdata;
            wr_total <= wr_total + 1;
        end
        if (s_imem_we === 1'b1) begin
            s_last_addr <= s_imem_addr;
            s_last_data <= s_imem_wdata;
            s_wr_total  <= s_wr_total + 1;
        end
    end

    task automatic do_reset();
        @(posedge clock); #3;
        reset = 1'b1;
        @(posedge clock); @(posedge clock); #3;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input int gap);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            if (sel) begin s_rx_valid = 1'b0; s_rx_data = 8'hFF; end
            else     begin rx_valid   = 1'b0; rx_data   = 8'hFF; end
            @(posedge clock); #1;
        end
        if (sel) begin s_rx_valid = 1'b1; s_rx_data = b; end
        else     begin rx_valid   = 1'b1; rx_data   = b; end
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clock);
            ok = sel ? s_rx_ready : rx_ready;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout: rx_ready stayed 0, required 1 (byte %h)", b);
        end
        @(posedge clock); #1;
        if (sel) begin s_rx_valid = 1'b0; s_rx_data = 8'h00; end
        else     begin rx_valid   = 1'b0; rx_data   = 8'h00; end
    endtask

    task automatic test_reset();
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error} !==
            {1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wd=%h cr=%b dn=%b er=%b, required 1 0 000 00000000 1 0 0",
                     rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error);
        end
        @(posedge clock); #3;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({rx_ready, core_reset, done, error} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_idle: got rdy=%b cr=%b dn=%b er=%b, required 1 1 0 0",
                     rx_ready, core_reset, done, error);
        end
    endtask

    task automatic test_nominal();
        int base;
        do_reset();
        base = wr_total;
        for (int i = 0; i < 13; i++) begin
            send(1'b0, NOM[i], 0);
            if (i == 7) begin
                checks++;
                if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h00000093}) begin
                    failures++;
                    $display("FAIL nom_write0: got we=%b addr=%h data=%h, required 1 000 00000093",
                             imem_we, imem_addr, imem_wdata);
                end
            end
            if (i == 11) begin
                checks++;
                if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd1, 32'h00100113}) begin
                    failures++;
                    $display("FAIL nom_write1: got we=%b addr=%h data=%h, required 1 001 00100113",
                             imem_we, imem_addr, imem_wdata);
                end
            end
        end
        checks++;
        if ({core_reset, rx_ready, done} !== 3'b100) begin
            failures++;
            $display("FAIL nom_hold_entry: got cr=%b rdy=%b dn=%b, required 1 0 0", core_reset, rx_ready, done);
        end
        for (int k = 1; k < 4; k++) begin
            @(posedge clock); #1;
            checks++;
            if ({core_reset, done} !== 2'b10) begin
                failures++;
                $display("FAIL nom_hold_%0d: got cr=%b dn=%b, required 1 0", k, core_reset, done);
            end
        end
        @(posedge clock); #1;
        checks++;
        if ({core_reset, done, error} !== 3'b010) begin
            failures++;
            $display("FAIL nom_release: got cr=%b dn=%b er=%b, required 0 1 0", core_reset, done, error);
        end
        checks++;
        if (wr_total - base !== 2) begin
            failures++;
            $display("FAIL nom_write_count: got %0d, required 2", wr_total - base);
        end
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (5) @(posedge clock);
        #1;
        rx_valid = 1'b0;
        checks++;
        if ({done, rx_ready, core_reset, wr_total - base} !== {1'b1, 1'b0, 1'b0, 32'd2}) begin
            failures++;
            $display("FAIL nom_run_terminal: got dn=%b rdy=%b cr=%b writes=%0d, required 1 0 0 2",
                     done, rx_ready, core_reset, wr_total - base);
        end
    endtask

    task automatic test_gaps();
        int base;
        do_reset();
        base = wr_total;
        for (int i = 0; i < 13; i++) send(1'b0, NOM[i], $urandom_range(0, 3));
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (wr_total - base !== 2) begin
            failures++;
            $display("FAIL gap_write_count: got %0d, required 2", wr_total - base);
        end
        checks++;
        if ({wr_addr_log[base % 64], wr_data_log[base % 64]} !== {10'd0, 32'h00000093}) begin
            failures++;
            $display("FAIL gap_write0: got addr=%h data=%h, required 000 00000093",
                     wr_addr_log[base % 64], wr_data_log[base % 64]);
        end
        checks++;
        if ({wr_addr_log[(base + 1) % 64], wr_data_log[(base + 1) % 64]} !== {10'd1, 32'h00100113}) begin
            failures++;
            $display("FAIL gap_write1: got addr=%h data=%h, required 001 00100113",
                     wr_addr_log[(base + 1) % 64], wr_data_log[(base + 1) % 64]);
        end
        checks++;
        if ({done, core_reset, error} !== 3'b100) begin
            failures++;
            $display("FAIL gap_done: got dn=%b cr=%b er=%b, required 1 0 0", done, core_reset, error);
        end
    endtask

    task automatic test_bad_csum();
        int base;
        do_reset();
        base = wr_total;
        for (int i = 0; i < 12; i++) send(1'b0, NOM[i], 0);
        send(1'b0, 8'hB8, 0);
        checks++;
        if ({error, core_reset, rx_ready, done} !== 4'b1100) begin
            failures++;
            $display("FAIL bad_csum_error: got er=%b cr=%b rdy=%b dn=%b, required 1 1 0 0",
                     error, core_reset, rx_ready, done);
        end
        rx_valid = 1'b1; rx_data = 8'h00;
        repeat (20) @(posedge clock);
        #1;
        rx_valid = 1'b0;
        checks++;
        if ({error, core_reset, rx_ready, done, wr_total - base} !== {4'b1100, 32'd2}) begin
            failures++;
            $display("FAIL bad_csum_terminal: got er=%b cr=%b rdy=%b dn=%b writes=%0d, required 1 1 0 0 2",
                     error, core_reset, rx_ready, done, wr_total - base);
        end
    endtask

    task automatic test_oversize();
        int base;
        do_reset();
        base = s_wr_total;
        send(1'b1, 8'h05, 0); send(1'b1, 8'h00, 0); send(1'b1, 8'h00, 0); send(1'b1, 8'h00, 0);
        checks++;
        if ({s_error, s_core_reset, s_rx_ready, s_done} !== 4'b1100) begin
            failures++;
            $display("FAIL oversize_error: got er=%b cr=%b rdy=%b dn=%b, required 1 1 0 0",
                     s_error, s_core_reset, s_rx_ready, s_done);
        end
        s_rx_valid = 1'b1; s_rx_data = 8'h11;
        repeat (12) @(posedge clock);
        #1;
        s_rx_valid = 1'b0;
        checks++;
        if (s_wr_total - base !== 0) begin
            failures++;
            $display("FAIL oversize_no_write: got %0d writes, required 0", s_wr_total - base);
        end
    endtask

    task automatic test_full_capacity();
        int base;
        do_reset();
        base = s_wr_total;
        send(1'b1, 8'h04, 0); send(1'b1, 8'h00, 0); send(1'b1, 8'h00, 0); send(1'b1, 8'h00, 0);
        checks++;
        if ({s_error, s_rx_ready} !== 2'b01) begin
            failures++;
            $display("FAIL capacity_accept: got er=%b rdy=%b, required 0 1", s_error, s_rx_ready);
        end
        for (int w = 1; w <= 4; w++) begin
            send(1'b1, 8'(w), 0); send(1'b1, 8'h00, 0); send(1'b1, 8'h00, 0); send(1'b1, 8'h00, 0);
        end
        send(1'b1, 8'h0E, 0);
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if ({s_done, s_error, s_wr_total - base, s_last_addr, s_last_data} !==
            {1'b1, 1'b0, 32'd4, 2'd3, 32'h00000004}) begin
            failures++;
            $display("FAIL capacity_load: got dn=%b er=%b writes=%0d last_addr=%0d last_data=%h, required 1 0 4 3 00000004",
                     s_done, s_error, s_wr_total - base, s_last_addr, s_last_data);
        end
    endtask

    task automatic test_empty();
        int base;
        do_reset();
        base = wr_total;
        for (int i = 0; i < 5; i++) send(1'b0, 8'h00, 0);
        checks++;
        if ({core_reset, done, error} !== 3'b100) begin
            failures++;
            $display("FAIL empty_hold: got cr=%b dn=%b er=%b, required 1 0 0", core_reset, done, error);
        end
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if ({core_reset, done, error, wr_total - base} !== {3'b010, 32'd0}) begin
            failures++;
            $display("FAIL empty_run: got cr=%b dn=%b er=%b writes=%0d, required 0 1 0 0",
                     core_reset, done, error, wr_total - base);
        end
    endtask

    task automatic test_async_reset();
        int base;
        do_reset();
        for (int i = 0; i < 8; i++) send(1'b0, NOM[i], 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({core_reset, imem_we, rx_ready, done, error} !== 5'b10100) begin
            failures++;
            $display("FAIL async_reset: got cr=%b we=%b rdy=%b dn=%b er=%b, required 1 0 1 0 0",
                     core_reset, imem_we, rx_ready, done, error);
        end
        @(posedge clock); #3;
        reset = 1'b0;
        @(posedge clock); #1;
        base = wr_total;
        for (int i = 0; i < 13; i++) send(1'b0, NOM[i], 0);
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if ({wr_total - base, wr_addr_log[base % 64], wr_data_log[base % 64],
             wr_addr_log[(base + 1) % 64], wr_data_log[(base + 1) % 64], done} !==
            {32'd2, 10'd0, 32'h00000093, 10'd1, 32'h00100113, 1'b1}) begin
            failures++;
            $display("FAIL async_reload: got writes=%0d w0=%h:%h w1=%h:%h dn=%b, required 2 000:00000093 001:00100113 1",
                     wr_total - base, wr_addr_log[base % 64], wr_data_log[base % 64],
                     wr_addr_log[(base + 1) % 64], wr_data_log[(base + 1) % 64], done);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        s_rx_valid = 1'b0;
        s_rx_data  = 8'h00;
        test_reset();
        test_nominal();
        test_gaps();
        test_bad_csum();
        test_oversize();
        test_full_capacity();
        test_empty();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
